// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to
// instruction memory under a credit limit, buffers returned words in an
// in-order prefetch FIFO and hands {instr_raw, instr_pc} to decode.
// Redirects flush the FIFO and discard every response still in flight.
//
// Handshakes: imem transfers a request on imem_req && imem_gnt, and
// imem_req/imem_addr stay stable until that happens. Decode transfers on
// instr_valid && instr_ready, and the instr_* outputs stay stable while
// instr_valid && !instr_ready.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_raw,
  output logic [31:0] instr_pc,
  output logic        instr_misaligned
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W   = FIFO_DEPTH[CW:0];
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [31:0]           fetch_pc;
  logic [31:0]           resp_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         discard;
  logic [CW-1:0]         fifo_count;
  logic                  halted;
  logic [31:0]           fifo_raw [FIFO_DEPTH];
  logic [31:0]           fifo_pc  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_mis;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;

  logic                  grant;
  logic                  pop;
  logic                  resp_push;
  logic                  redirect_misaligned;
  logic [CW-1:0]         outstanding_nxt;

  // A request is only allowed while in-flight plus buffered words leave
  // room in the FIFO, so every response always has a slot waiting for it.
  // rst_n gates the request so nothing is asked for while held in reset.
  assign imem_req  = rst_n && !halted &&
                     (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W);
  assign imem_addr = fetch_pc;

  assign grant               = imem_req && imem_gnt;
  assign pop                 = instr_valid && instr_ready;
  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  // A response arriving in a redirect cycle belongs to the old stream.
  assign resp_push           = imem_rvalid && !redirect_valid && (discard == '0);

  assign instr_valid      = (fifo_count != '0);
  assign instr_raw        = fifo_raw[rd_ptr];
  assign instr_pc         = fifo_pc[rd_ptr];
  assign instr_misaligned = fifo_mis[rd_ptr];

  // In-flight count after this cycle's grant and response.
  always_comb begin
    outstanding_nxt = outstanding + CW'(grant) - CW'(imem_rvalid);
  end

  // Fetch PC, response PC, credit and discard bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      halted      <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle is stale; that count
        // already includes any older discards still pending.
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        discard  <= outstanding_nxt;
        halted   <= redirect_misaligned;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (imem_rvalid && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (resp_push) begin
          resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

  // Prefetch FIFO: flushed on redirect, seeded with a fault entry when the
  // redirect target is not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      fifo_mis   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_raw[i] <= '0;
        fifo_pc[i]  <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      if (redirect_misaligned) begin
        fifo_raw[0] <= NOP_INSTR;
        fifo_pc[0]  <= redirect_pc;
        fifo_mis[0] <= 1'b1;
        wr_ptr      <= AW'(1);
        fifo_count  <= CW'(1);
      end else begin
        wr_ptr     <= '0;
        fifo_count <= '0;
      end
    end else begin
      if (resp_push) begin
        fifo_raw[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]  <= resp_pc;
        fifo_mis[wr_ptr] <= 1'b0;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count <= fifo_count + CW'(resp_push) - CW'(pop);
    end
  end

endmodule
